data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Multi-cycle data-memory responder on the far end of the MEM-stage load/store request interface.
- Accepts one request at a time from the EX/MEM pipeline register.
- Performs byte, half or word access with RISC-V lane selection and sign/zero extension, then returns a single-cycle response.
- Drives mem_stall so the pipeline freezes the MEM stage until the response cycle.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; must be a power of two.
- LATENCY, 2, wait cycles between accept and access, range 0..15.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clock.
- req_valid  in  1  MEM stage holds a load or store.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data (rs2 value); the low byte/half is used for sb/sh.
- req_funct3  in  3  instruction funct3.
- req_ready  out  1  high only in IDLE.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  load result, already extended; 0 for stores and errors.
- rsp_err  out  1  valid with rsp_valid: misaligned, unsupported funct3, or out-of-range address.
- mem_stall  out  1  freeze the PC, IF/ID, ID/EX and EX/MEM registers.

Behaviour:
- FSM states are IDLE, BUSY and RESP.
- Reset (reset==0 at an edge):
  - state returns to IDLE, wait counter goes to 0.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - Memory array is not cleared.
- Accept: in IDLE, req_valid=1 captures we, addr, wdata and funct3 on that edge.
  - Next state is BUSY with the counter loaded to LATENCY-1.
  - If LATENCY=0, next state is RESP directly.
- BUSY: the counter decrements each cycle; when it reaches 0, next state is RESP.
- Access happens on the edge entering RESP, using the captured request only.
  - Store: writes only the enabled byte lanes.
  - Load: reads the addressed word, then selects and extends the lane.
- Timing: accept at cycle T gives rsp_valid at cycle T+LATENCY+1. rsp_valid is high for exactly one cycle (RESP); the next state is always IDLE.
- req_ready: high in IDLE only. In RESP, a still-high req_valid is the same instruction and must not be re-accepted.
- mem_stall = (IDLE && req_valid) || BUSY. It is low in RESP, so the pipeline advances out of MEM on the RESP edge.
- Loads by funct3, with byte offset a = addr[1:0]:
  - 000 lb: byte a, sign-extended.
  - 001 lh: half addr[1], sign-extended.
  - 010 lw: full word.
  - 100 lbu: byte a, zero-extended.
  - 101 lhu: half addr[1], zero-extended.
- Stores by funct3:
  - 000 sb: lane a gets wdata[7:0].
  - 001 sh: lanes 2*addr[1] and 2*addr[1]+1 get wdata[15:0].
  - 010 sw: all four lanes get wdata.
- Byte order is little-endian.
- Word index = addr[log2(DEPTH_WORDS)+1:2].
- Errors:
  - Causes: lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0; any other funct3; addr[31:log2(DEPTH_WORDS)+2] non-zero.
  - Response: rsp_err=1, rsp_rdata=0, no memory write. Full latency is still observed.
- Reset mid-operation (BUSY): the request is dropped, no write occurs, and no rsp_valid is produced.
- A change in request inputs during BUSY is ignored; only captured values are used.

Decomposition:
- cpu_pkg gains:
  - mem_req_t struct {we, addr[31:0], wdata[31:0], funct3[2:0]}.
  - dmem_state_t enum {IDLE, BUSY, RESP}.
  - funct3 localparams F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
- Sub-module dmem_lane_align (combinational) takes funct3, addr[1:0], wdata and the read word. It produces:
  - byte-enable[3:0]
  - shifted write data
  - extended load data
  - misalign flag
- Top-level FSM, counter and array stay in data_mem_responder.

Test Plan:
- LATENCY=2: sw addr 0x10 data 0x8899AABB; lw 0x10 → rsp_valid at T+3, rdata 0x8899AABB, rsp_err=0; mem_stall high for T, T+1, T+2 and low at T+3.
- After the word above: lb 0x13 → 0xFFFFFF88; lbu 0x13 → 0x00000088; lh 0x12 → 0xFFFF8899; lhu 0x10 → 0x0000AABB.
- sb 0x11 data 0x000000CC, then lw 0x10 → 0x8899CCBB; sh 0x12 data 0x00001234 → lw 0x10 gives 0x1234CCBB.
- Errors: lw 0x12 → rsp_err=1, rdata 0; sw 0x11 leaves the word unchanged; lw 0x400 (DEPTH_WORDS=256) → rsp_err=1; funct3=011 → rsp_err=1.
- Hold req_valid high through RESP and the following IDLE with the same sw: exactly two accepts occur, ready is never high in RESP, and no extra response appears.
- Assert reset low during BUSY of sw 0x20 data 0xDEADBEEF: no rsp_valid follows and all outputs are 0; lw 0x20 afterwards returns the prior contents.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types for the MEM-stage data memory: request record, responder
// FSM states and the load/store funct3 encodings.
package cpu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } dmem_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
  } mem_req_t;

  // Stores only exist as sb/sh/sw; loads add the unsigned byte/half forms.
  function automatic logic f3_supported(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering for RISC-V loads and stores: byte enables,
// replicated store data, extended load data and the misalignment flag.
module dmem_lane_align
  import cpu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = rword[{addr_lo, 3'b000} +: 8];
  assign rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];

  // NOTE: every output gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    byte_en   = 4'b0000;
    wdata_sh  = 32'h0;
    rdata_ext = 32'h0;
    misalign  = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        byte_en   = 4'b0001 << addr_lo;
        wdata_sh  = {4{wdata[7:0]}};
        rdata_ext = (funct3 == F3_B) ? {{24{rbyte[7]}}, rbyte} : {24'h0, rbyte};
      end
      F3_H, F3_HU: begin
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_sh  = {2{wdata[15:0]}};
        rdata_ext = (funct3 == F3_H) ? {{16{rhalf[15]}}, rhalf} : {16'h0, rhalf};
        misalign  = addr_lo[0];
      end
      F3_W: begin
        byte_en   = 4'b1111;
        wdata_sh  = wdata;
        rdata_ext = rword;
        misalign  = (addr_lo != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory behind the MEM-stage request port: one request at a
// time, fixed wait latency, single-cycle response pulse and pipeline stall.
module data_mem_responder
  import cpu_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_stall
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam int         AW       = IDX_W + 2;
  localparam logic [3:0] LAT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  dmem_state_t      state;
  logic [3:0]       wait_cnt;
  mem_req_t         req_q;
  mem_req_t         req_in;
  mem_req_t         acc;
  logic [31:0]      mem [DEPTH_WORDS];

  logic [IDX_W-1:0] word_idx;
  logic [31:0]      rword;
  logic [3:0]       byte_en;
  logic [31:0]      wdata_sh;
  logic [31:0]      rdata_ext;
  logic             misalign;
  logic             range_err;
  logic             err;
  logic             accept;
  logic             to_resp;
  logic             write_en;

  assign req_in    = '{we: req_we, addr: req_addr, wdata: req_wdata, funct3: req_funct3};
  assign accept    = (state == IDLE) && req_valid;
  assign to_resp   = ((state == BUSY) && (wait_cnt == 4'd0)) || (accept && (LATENCY == 0));

  // With zero latency the access edge is the accept edge, so the live request
  // is used; otherwise only the captured copy is.
  assign acc       = (state == IDLE) ? req_in : req_q;

  assign word_idx  = acc.addr[AW-1:2];
  assign rword     = mem[word_idx];
  assign range_err = |(acc.addr >> AW);
  assign err       = misalign || range_err || !f3_supported(acc.we, acc.funct3);
  assign write_en  = to_resp && acc.we && !err && reset;

  assign req_ready = (state == IDLE);
  assign mem_stall = accept || (state == BUSY);

  dmem_lane_align u_align (
    .funct3    (acc.funct3),
    .addr_lo   (acc.addr[1:0]),
    .wdata     (acc.wdata),
    .rword     (rword),
    .byte_en   (byte_en),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext),
    .misalign  (misalign)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      req_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
      case (state)
        IDLE: if (req_valid) begin
          req_q <= req_in;
          if (LATENCY == 0) begin
            state <= RESP;
          end else begin
            state    <= BUSY;
            wait_cnt <= LAT_LOAD;
          end
        end
        BUSY: begin
          if (wait_cnt == 4'd0) state <= RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (to_resp) begin
        rsp_valid <= 1'b1;
        rsp_err   <= err;
        rsp_rdata <= (err || acc.we) ? 32'h0 : rdata_ext;
      end
    end
  end

  // NOTE: the array has no reset; contents survive reset and it maps onto RAM.
  always_ff @(posedge clock) begin
    if (write_en) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (DEPTH_WORDS=256, LATENCY=2).
module tb_data_mem_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [2:0]  req_funct3 = 3'b000;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_stall;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_stall  (mem_stall)
  );

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // One transaction, req_valid held until the response cycle. lat counts edges
  // from the accept edge to the sample showing rsp_valid (-1 on timeout).
  task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, output logic [31:0] rd, output logic er,
                         output int lat, output logic stall_ok, output logic pulse_ok);
    @(negedge clock);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
    #1;
    stall_ok = (mem_stall === 1'b1) && (req_ready === 1'b1);
    lat = -1; rd = 32'hx; er = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clock); #1;
      if (rsp_valid === 1'b1) begin
        lat = c; rd = rsp_rdata; er = rsp_err;
        if (mem_stall !== 1'b0 || req_ready !== 1'b0) stall_ok = 1'b0;
        break;
      end
      if (mem_stall !== 1'b1) stall_ok = 1'b0;
    end
    @(negedge clock);
    req_valid = 1'b0;
    @(posedge clock); #1;
    pulse_ok = (rsp_valid === 1'b0) && (req_ready === 1'b1);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    total++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== 34'h0) begin
      bad++; $display("FAIL reset_rsp got valid=%b err=%b rdata=%h exp 0/0/0", rsp_valid, rsp_err, rsp_rdata);
    end
    total++;
    if (req_ready !== 1'b1 || mem_stall !== 1'b0) begin
      bad++; $display("FAIL reset_idle got ready=%b stall=%b exp 1/0", req_ready, mem_stall);
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er, so, po; int lat;
    run_req(1'b1, 32'h10, 32'h8899AABB, 3'b010, rd, er, lat, so, po);
    total++;
    if (er !== 1'b0 || rd !== 32'h0 || lat !== 3) begin
      bad++; $display("FAIL sw_word got err=%b rdata=%h lat=%0d exp 0/00000000/3", er, rd, lat);
    end
    run_req(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat, so, po);
    total++;
    if (rd !== 32'h8899AABB || er !== 1'b0) begin
      bad++; $display("FAIL lw_word got rdata=%h err=%b exp 8899aabb/0", rd, er);
    end
    total++;
    if (lat !== 3) begin
      bad++; $display("FAIL lw_latency got %0d exp 3", lat);
    end
    total++;
    if (so !== 1'b1) begin
      bad++; $display("FAIL lw_stall_ready got ok=%b exp 1", so);
    end
    total++;
    if (po !== 1'b1) begin
      bad++; $display("FAIL lw_single_pulse got ok=%b exp 1", po);
    end
  endtask

  task automatic test_loads();
    logic [31:0] addrs [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
    logic [2:0]  f3s   [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] exps  [4] = '{32'hFFFFFF88, 32'h00000088, 32'hFFFF8899, 32'h0000AABB};
    logic [31:0] rd; logic er, so, po; int lat;
    for (int i = 0; i < 4; i++) begin
      run_req(1'b0, addrs[i], 32'h0, f3s[i], rd, er, lat, so, po);
      total++;
      if (rd !== exps[i] || er !== 1'b0 || lat !== 3) begin
        bad++; $display("FAIL load_ext[%0d] got rdata=%h err=%b lat=%0d exp %h/0/3", i, rd, er, lat, exps[i]);
      end
    end
  endtask

  task automatic test_stores();
    logic [31:0] rd; logic er, so, po; int lat;
    run_req(1'b1, 32'h11, 32'h000000CC, 3'b000, rd, er, lat, so, po);
    run_req(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat, so, po);
    total++;
    if (rd !== 32'h8899CCBB) begin
      bad++; $display("FAIL sb_lane got %h exp 8899ccbb", rd);
    end
    run_req(1'b1, 32'h12, 32'h00001234, 3'b001, rd, er, lat, so, po);
    run_req(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat, so, po);
    total++;
    if (rd !== 32'h1234CCBB) begin
      bad++; $display("FAIL sh_lane got %h exp 1234ccbb", rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er, so, po; int lat;
    run_req(1'b0, 32'h12, 32'h0, 3'b010, rd, er, lat, so, po);
    total++;
    if (er !== 1'b1 || rd !== 32'h0 || lat !== 3) begin
      bad++; $display("FAIL lw_misalign got err=%b rdata=%h lat=%0d exp 1/00000000/3", er, rd, lat);
    end
    run_req(1'b1, 32'h11, 32'hFFFFFFFF, 3'b010, rd, er, lat, so, po);
    total++;
    if (er !== 1'b1) begin
      bad++; $display("FAIL sw_misalign_err got %b exp 1", er);
    end
    run_req(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat, so, po);
    total++;
    if (rd !== 32'h1234CCBB) begin
      bad++; $display("FAIL sw_misalign_nowrite got %h exp 1234ccbb", rd);
    end
    run_req(1'b0, 32'h400, 32'h0, 3'b010, rd, er, lat, so, po);
    total++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      bad++; $display("FAIL lw_range got err=%b rdata=%h exp 1/00000000", er, rd);
    end
    run_req(1'b0, 32'h10, 32'h0, 3'b011, rd, er, lat, so, po);
    total++;
    if (er !== 1'b1 || rd !== 32'h0 || lat !== 3) begin
      bad++; $display("FAIL bad_funct3 got err=%b rdata=%h lat=%0d exp 1/00000000/3", er, rd, lat);
    end
    run_req(1'b1, 32'h11, 32'h0, 3'b100, rd, er, lat, so, po);
    total++;
    if (er !== 1'b1) begin
      bad++; $display("FAIL store_funct3_100 got err=%b exp 1", er);
    end
  endtask

  task automatic test_back_to_back();
    int accepts = 0, rsps = 0, ready_in_resp = 0;
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h11223344; req_funct3 = 3'b010;
    #1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin
        @(posedge clock); #1;
      end
      if (req_valid && req_ready === 1'b1) accepts++;
      if (rsp_valid === 1'b1) begin
        rsps++;
        if (req_ready !== 1'b0) ready_in_resp++;
      end
      if (rsps == 2) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    total++;
    if (accepts !== 2) begin
      bad++; $display("FAIL hold_accepts got %0d exp 2", accepts);
    end
    total++;
    if (rsps !== 2) begin
      bad++; $display("FAIL hold_responses got %0d exp 2", rsps);
    end
    total++;
    if (ready_in_resp !== 0) begin
      bad++; $display("FAIL hold_ready_in_resp got %0d exp 0", ready_in_resp);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er, so, po; int lat;
    int late_rsp = 0;
    run_req(1'b1, 32'h20, 32'h0BADF00D, 3'b010, rd, er, lat, so, po);
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hDEADBEEF; req_funct3 = 3'b010;
    @(posedge clock); #1;
    total++;
    if (mem_stall !== 1'b1 || req_ready !== 1'b0) begin
      bad++; $display("FAIL mid_busy got stall=%b ready=%b exp 1/0", mem_stall, req_ready);
    end
    @(negedge clock);
    reset = 1'b0; req_valid = 1'b0;
    @(posedge clock); #1;
    total++;
    if ({rsp_valid, rsp_err, rsp_rdata, mem_stall} !== 35'h0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL mid_reset_out got valid=%b err=%b rdata=%h stall=%b ready=%b exp 0/0/0/0/1",
                      rsp_valid, rsp_err, rsp_rdata, mem_stall, req_ready);
    end
    @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clock); #1;
      if (rsp_valid !== 1'b0) late_rsp++;
    end
    total++;
    if (late_rsp !== 0) begin
      bad++; $display("FAIL mid_reset_no_rsp got %0d exp 0", late_rsp);
    end
    run_req(1'b0, 32'h20, 32'h0, 3'b010, rd, er, lat, so, po);
    total++;
    if (rd !== 32'h0BADF00D || er !== 1'b0) begin
      bad++; $display("FAIL mid_reset_nowrite got rdata=%h err=%b exp 0badf00d/0", rd, er);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_loads();
    test_stores();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
